// File: rtl/led_fade_pwm.sv
// Per-LED afterglow: channels driven high light at full brightness, then fade out via PWM
// once released. Bypass passes led_in through with one register stage.
module led_fade_pwm #(
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned DECAY_BASE = 10000
) (
  input  logic       clk_10MHz,
  input  logic       rst,
  input  logic [7:0] led_in,
  input  logic [1:0] fade_sel,
  input  logic       bypass,
  output logic [7:0] pwm_out,
  output logic       decay_tick
);

  localparam logic [PWM_BITS-1:0] LevelMax  = {PWM_BITS{1'b1}};
  localparam logic [15:0]         PrescLast = 16'(DECAY_BASE - 1);

  logic [15:0]               presc_q, presc_d;
  logic [2:0]                div_cnt_q, div_cnt_d;
  logic [PWM_BITS-1:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0][PWM_BITS-1:0]  level_q, level_d;
  logic [7:0]                pwm_out_q, pwm_out_d;
  logic                      base_tick;
  logic [2:0]                mask;

  always_comb begin
    mask = 3'b000;
    unique case (fade_sel)
      2'd0: mask = 3'b000;
      2'd1: mask = 3'b001;
      2'd2: mask = 3'b011;
      2'd3: mask = 3'b111;
      default: mask = 3'b000;
    endcase
  end

  assign base_tick  = (presc_q == PrescLast);
  assign decay_tick = base_tick & ((div_cnt_q & mask) == mask);

  always_comb begin
    presc_d   = base_tick ? 16'd0 : presc_q + 16'd1;
    div_cnt_d = base_tick ? div_cnt_q + 3'd1 : div_cnt_q;
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    level_d   = level_q;
    pwm_out_d = '0;
    for (int i = 0; i < 8; i++) begin
      // A fresh led_in wins over a simultaneous decay step.
      if (led_in[i]) begin
        level_d[i] = LevelMax;
      end else if (decay_tick && (level_q[i] != '0)) begin
        level_d[i] = level_q[i] - PWM_BITS'(1);
      end
      pwm_out_d[i] = (level_q[i] == LevelMax) | (level_q[i] > pwm_cnt_q);
    end
    if (bypass) begin
      pwm_out_d = led_in;
    end
  end

  always_ff @(posedge clk_10MHz) begin
    if (rst) begin
      presc_q   <= '0;
      div_cnt_q <= '0;
      pwm_cnt_q <= '0;
      level_q   <= '0;
      pwm_out_q <= '0;
    end else begin
      presc_q   <= presc_d;
      div_cnt_q <= div_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      level_q   <= level_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule
